// File: rtl/ip_sync_fifo.sv
// ip_sync_fifo: single-clock FIFO with registered occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Define IP_SYNC_FIFO_FWFT_EN to build the first-word-fall-through
// variant. With it, dout shows the head entry combinationally and
// rd_valid = !empty. Without it, dout is registered with one cycle of
// read latency.
module ip_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    cnt;
  logic             ovf_q;
  logic             unf_q;
  logic             wr_acc;
  logic             rd_acc;

  // Status flags decoded only from the registered count
  always_comb begin
    full         = (cnt == DEPTH_C);
    empty        = (cnt == '0);
    almost_full  = (cnt >= AFULL_C);
    almost_empty = (cnt <= AEMPTY_C);
    count        = cnt;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  // Acceptance: a full FIFO rejects writes and an empty FIFO rejects reads
  always_comb begin
    wr_acc = wr_en && !full;
    rd_acc = rd_en && !empty;
  end

  // Pointers, occupancy and sticky error flags; clr outranks traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + PW'(1);
        2'b01:   cnt <= cnt - PW'(1);
        default: cnt <= cnt;
      endcase
      if (wr_en && full)  ovf_q <= 1'b1;
      if (rd_en && empty) unf_q <= 1'b1;
    end
  end

  // Storage array, deliberately not reset; a flush leaves contents untouched
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

`ifdef IP_SYNC_FIFO_FWFT_EN
  // Head entry falls through; rd_en only pops the word already shown
  always_comb begin
    dout     = mem[rd_ptr[AW-1:0]];
    rd_valid = !empty;
  end
`else
  logic [WIDTH-1:0] dout_q;
  logic             rvld_q;

  // Registered read port: word captured on the accepting edge, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      rvld_q <= 1'b0;
    end else if (clr) begin
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Drive the read-port outputs from their registers
  always_comb begin
    dout     = dout_q;
    rd_valid = rvld_q;
  end
`endif

endmodule

// File: tb/tb_ip_sync_fifo.sv
// tb_ip_sync_fifo: directed and randomized checks of ip_sync_fifo against a
// queue-based reference model. It follows IP_SYNC_FIFO_FWFT_EN when that
// macro is defined.
module tb_ip_sync_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int AFULL_TH  = 3;
  localparam int AEMPTY_TH = 1;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int unsigned checks;
  int unsigned failures;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_rv;
  logic             m_ovf;
  logic             m_unf;

  ip_sync_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against what the model says now
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"},  32'(count),        32'(n));
    chk({tag, ":full"},   32'(full),         32'(n == DEPTH));
    chk({tag, ":empty"},  32'(empty),        32'(n == 0));
    chk({tag, ":afull"},  32'(almost_full),  32'(n >= AFULL_TH));
    chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AEMPTY_TH));
    chk({tag, ":ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ":unf"},    32'(underflow),    32'(m_unf));
`ifdef IP_SYNC_FIFO_FWFT_EN
    chk({tag, ":rvalid"}, 32'(rd_valid),     32'(n != 0));
    if (n != 0) chk({tag, ":dout"}, 32'(dout), 32'(q[0]));
`else
    chk({tag, ":rvalid"}, 32'(rd_valid),     32'(m_rv));
    chk({tag, ":dout"},   32'(dout),         32'(m_dout));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model over the edge, then check
  task automatic step(input logic w, input logic r, input logic c,
                      input logic [WIDTH-1:0] d, input string tag);
    int  n;
    logic wa, ra;
    @(negedge clk);
    wr_en = w; rd_en = r; clr = c; din = d;
    n  = q.size();
    wa = w && (n < DEPTH);
    ra = r && (n > 0);
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      m_rv = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill in order, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i), "fill");
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 1'b0, '0, "drain");
    step(1'b0, 1'b0, 1'b0, '0, "drain_idle");

    // Simultaneous write and read while full: write rejected
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i + 8'h20), "fill2");
    step(1'b1, 1'b1, 1'b0, 8'h55, "both_full");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, "after_ovf");
    step(1'b0, 1'b0, 1'b0, '0, "after_ovf_idle");

    // Simultaneous write and read while empty: read rejected
    step(1'b1, 1'b1, 1'b0, 8'hA0, "both_empty");
    step(1'b0, 1'b1, 1'b0, '0, "read_a0");
    step(1'b0, 1'b0, 1'b0, '0, "read_a0_idle");
    step(1'b0, 1'b0, 1'b1, '0, "clr_flags");

    // Streaming across pointer wraps
    step(1'b1, 1'b0, 1'b0, 8'h10, "stream_first");
    for (int i = 1; i < 10; i++) step(1'b1, 1'b1, 1'b0, WIDTH'(8'h10 + i), "stream");
    step(1'b0, 1'b1, 1'b0, '0, "stream_last");
    step(1'b0, 1'b0, 1'b0, '0, "stream_idle");

    // Flush outranks a concurrent write
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(8'h30 + i), "pre_clr");
    step(1'b1, 1'b1, 1'b0, 8'h44, "pre_clr_both");
    step(1'b0, 1'b1, 1'b0, '0, "pre_clr_ovf_try");
    step(1'b1, 1'b0, 1'b1, 8'h99, "clr_wr");

    // Write, then pop the head entry
    step(1'b1, 1'b0, 1'b0, 8'h7E, "wr_7e");
    step(1'b0, 1'b0, 1'b0, '0, "hold_7e");
    step(1'b0, 1'b1, 1'b0, '0, "pop_7e");
    step(1'b0, 1'b0, 1'b0, '0, "pop_7e_idle");

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0), WIDTH'($urandom), "rand");
    end

    // Reset asserted mid-stream, between clock edges
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "pre_rst");
    step(1'b1, 1'b1, 1'b0, 8'h66, "pre_rst_rd");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    step(1'b0, 1'b1, 1'b0, '0, "post_rst_rd");
    step(1'b1, 1'b0, 1'b0, 8'hC3, "post_rst_wr");
    step(1'b0, 1'b1, 1'b0, '0, "post_rst_pop");
    step(1'b0, 1'b0, 1'b0, '0, "post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ip_sync_fifo.md
IP_SYNC_FIFO -- requirements
Module: ip_sync_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clock port clk, reset port rst_n.
REQ-002 Parameter WIDTH, 8, data word width in bits (>=1).
REQ-003 Parameter DEPTH, 4, number of storage entries (power of two, >=2).
REQ-004 Parameter AFULL_TH, DEPTH-1, almost_full threshold (1..DEPTH).
REQ-005 Parameter AEMPTY_TH, 1, almost_empty threshold (0..DEPTH-1).
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 clr  in  1  synchronous flush of contents and sticky flags.
REQ-009 wr_en  in  1  write request.
REQ-010 din  in  WIDTH  write data.
REQ-011 rd_en  in  1  read request.
REQ-012 dout  out  WIDTH  read data.
REQ-013 rd_valid  out  1  dout holds a freshly read word.
REQ-014 full / empty  out  1 each  occupancy == DEPTH / == 0.
REQ-015 almost_full / almost_empty  out  1 each  count >= AFULL_TH / count <= AEMPTY_TH.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow / underflow  out  1 each  sticky: write while full / read while empty.

Function
REQ-018 Write SHALL be accepted iff wr_en && !full at the edge; din is stored at wr_ptr, wr_ptr increments.
REQ-019 Read SHALL be accepted iff rd_en && !empty at the edge; rd_ptr increments.
REQ-020 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap naturally; entry index = low bits; no data loss or duplication across wrap.
REQ-021 count SHALL update the edge after acceptance: +1 write only, -1 read only, unchanged on simultaneous accepted read and write.
REQ-022 full, empty, almost_full, almost_empty SHALL be decoded from registered count only; no combinational path from wr_en/rd_en.
REQ-023 Simultaneous wr_en and rd_en while full: read accepted, write rejected, overflow set.
REQ-024 Simultaneous wr_en and rd_en while empty: write accepted, read rejected, underflow set.
REQ-025 overflow/underflow SHALL stay set until clr or reset.
REQ-026 clr SHALL have priority over wr_en/rd_en in the same cycle: pointers, count, overflow, underflow, rd_valid go to 0; memory contents left unchanged; dout holds.

Reset
REQ-027 rst_n low SHALL immediately force pointers and count to 0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AFULL_TH==0, disallowed), overflow=0, underflow=0, rd_valid=0, registered dout=0.
REQ-028 Storage array SHALL NOT be reset; reset mid-operation discards all contents.

Configuration
REQ-029 Macro IP_SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-030 Without the macro: dout registered, updated with mem[rd_ptr] on the edge accepting a read (one-cycle latency); rd_valid high exactly one cycle per accepted read; dout holds otherwise.
REQ-031 With the macro: dout = mem[rd_ptr] combinationally, rd_valid = !empty; rd_en acts as pop/acknowledge of the word already on dout (zero latency).

Verification (WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-032 Write 0x01..0x04 back-to-back -> count 1,2,3,4; almost_full at count 3; full after 4th; then read 4 -> dout 0x01..0x04 in order (standard: one cycle after each rd_en), empty at end.
REQ-033 Fill to full, hold wr_en=rd_en=1 with din=0x55 one cycle -> count 3, overflow=1, 0x55 not stored, next reads return original sequence.
REQ-034 Empty FIFO, wr_en=rd_en=1, din=0xA0 -> count 1, underflow=1, next read returns 0xA0.
REQ-035 Continuous streaming 10 words 0x10..0x19 with simultaneous read/write after first write -> order preserved across two pointer wraps, count constant at 1, no flags set.
REQ-036 Write 3 words, assert clr with wr_en=1 -> count 0, empty=1, overflow/underflow cleared; assert rst_n=0 mid-stream -> all outputs at REQ-027 values before next clk edge.
REQ-037 Rebuild with IP_SYNC_FIFO_FWFT_EN, write 0x7E -> dout=0x7E and rd_valid=1 the cycle after write, before any rd_en; rd_en pop -> empty next cycle.
